compare_sched: RTL
==================

Name: compare_sched

Overview:
- Frame-level min/max scheduler built around one shared 4-bit magnitude comparator.
- Accepts a frame of FRAME_LEN 4-bit samples over a valid/ready handshake.
- Time-multiplexes the single comparator: each sample is compared first against the running max, then against the running min.
- Presents the frame max/min on an output handshake. Sits between a sample source and downstream decision logic.

Parameters:
- FRAME_LEN, 8, samples per frame; legal range 2..256.
- CNT_W, $clog2(FRAME_LEN), sample counter/index width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  sample present on in_data.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  4  unsigned sample.
- out_valid  output  1  frame result available.
- out_ack  input  1  consumer takes result.
- out_max  output  4  frame maximum.
- out_min  output  4  frame minimum.
- busy  output  1  frame in progress (state not IDLE).

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-low on rst_n: sampled on the rising edge of clk.
- Reset: state=IDLE; out_valid=0, out_max=0, out_min=0, busy=0; counter, sample register and running max/min cleared. Reset mid-frame abandons the frame; no partial result is output.
- Comparator encoding, one-hot y[2:0]: 001 a>b, 010 a==b, 100 a<b, unsigned.
- in_ready is combinational from state: 1 in IDLE and ACCEPT only. Transfer occurs when in_valid&&in_ready.
- IDLE: on transfer, max<=in_data, min<=in_data, cnt<=1, go ACCEPT.
- ACCEPT: on transfer, smp<=in_data, go CMP_MAX. Otherwise hold.
- CMP_MAX: comparator a=smp, b=max. If y==001, max<=smp. Go CMP_MIN.
- CMP_MIN: comparator a=smp, b=min. If y==100, min<=smp. Then cnt<=cnt+1. If cnt==FRAME_LEN-1, go DONE; else go ACCEPT.
- DONE: out_valid=1; out_max/out_min driven from the running registers and held stable. On out_ack, go IDLE; out_valid drops the next cycle. in_ready=0 throughout DONE (backpressure).
- Throughput: 1 cycle for the first sample, 3 cycles per subsequent sample.
- Latency: with in_valid held high, out_valid rises 3*(FRAME_LEN-1)+1 cycles after the first transfer edge.
- Ties: equal values never update max/min, so the first occurrence wins.
- out_ack outside DONE is ignored. out_ack in the same cycle out_valid first rises is accepted.
- out_max/out_min retain the last frame's values in IDLE/ACCEPT.
- Counter never wraps: it is bounded by the transition to DONE.

Optional Feature:
- Macro: COMPARE_SCHED_INDEX_EN.
- Defined: adds outputs out_max_idx and out_min_idx, each CNT_W wide.
  - Both are set to 0 on the IDLE transfer.
  - Each is updated to cnt whenever the corresponding max/min updates (first occurrence on ties).
  - Both reset to 0 and are valid with out_valid.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Decomposition:
- Package compare_sched_pkg holds:
  - state enum: IDLE, ACCEPT, CMP_MAX, CMP_MIN, DONE;
  - comparator result constants CMP_GT=3'b001, CMP_EQ=3'b010, CMP_LT=3'b100;
  - DATA_W=4.
- One sub-module, cmp4_onehot: combinational 4-bit unsigned compare producing the one-hot y.
  - Instantiated exactly once; its operands are muxed by state.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles mid-frame (after 4 samples), then release -> busy=0, out_valid=0, out_max=out_min=0, in_ready=1 on the first cycle after release. A fresh 8-sample frame then completes normally.
2. Basic frame, FRAME_LEN=8, in_valid always high, samples 3,9,1,9,0,15,7,0 -> out_max=15, out_min=0, out_valid rises 22 cycles after the first transfer. With INDEX_EN: max_idx=5, min_idx=4.
3. Boundary values: samples all 4'hF -> max=min=15, idx 0/0. Then samples 0,15,0,15,... -> max=15 idx1, min=0 idx0.
4. Gapped input: in_valid toggles 1/0 per cycle -> in_ready asserted only in IDLE/ACCEPT, no sample lost or duplicated. Result matches the reference min/max of the accepted stream.
5. Output backpressure: out_ack held 0 for 10 cycles -> out_valid, out_max, out_min stable, in_ready=0 while in_valid=1. On out_ack=1, out_valid=0 next cycle and the next frame is accepted.
6. FRAME_LEN=2, samples 6,2 -> out_max=6, out_min=2, out_valid 4 cycles after the first transfer.

Source files
------------

// File: rtl/compare_sched_pkg.sv
// compare_sched_pkg: shared types and constants for the min/max scheduler
package compare_sched_pkg;
  localparam int DATA_W = 4;
  localparam logic [2:0] CMP_GT = 3'b001;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b100;
  typedef enum logic [2:0] {IDLE, ACCEPT, CMP_MAX, CMP_MIN, DONE} state_t;
endpackage

// File: rtl/compare_sched_cmp4_onehot.sv
// cmp4_onehot: combinational unsigned compare, one-hot y (001 a>b, 010 a==b, 100 a<b)
// Ports: i_a, i_b operands; o_y one-hot result.
module cmp4_onehot import compare_sched_pkg::*; (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [2:0]        o_y
);
  always_comb o_y = i_a > i_b ? CMP_GT : i_a < i_b ? CMP_LT : CMP_EQ;
endmodule

// File: rtl/compare_sched.sv
// compare_sched: frame min/max scheduler time-sharing one 4-bit comparator
// Ports: clk; rst_n sync active-low; in_valid/in_ready/in_data sample input;
// out_valid/out_ack/out_max/out_min frame result; busy = frame in progress.
// Macro COMPARE_SCHED_INDEX_EN adds out_max_idx/out_min_idx (sample position of extremes).
module compare_sched import compare_sched_pkg::*; #(
  parameter  int FRAME_LEN = 8,
  localparam int CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ack,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_min,
`ifdef COMPARE_SCHED_INDEX_EN
  output logic [CNT_W-1:0]  out_max_idx,
  output logic [CNT_W-1:0]  out_min_idx,
`endif
  output logic              busy
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_smp, r_max, r_min, r_out_max, r_out_min;
  logic              r_out_valid;
  logic              w_xfer;
  logic [DATA_W-1:0] w_b;
  logic [2:0]        w_y;
`ifdef COMPARE_SCHED_INDEX_EN
  logic [CNT_W-1:0]  r_max_idx, r_min_idx, r_out_max_idx, r_out_min_idx;
  assign out_max_idx = r_out_max_idx;
  assign out_min_idx = r_out_min_idx;
`endif
  assign in_ready  = r_state == IDLE || r_state == ACCEPT;
  assign busy      = r_state != IDLE;
  assign out_valid = r_out_valid;
  assign out_max   = r_out_max;
  assign out_min   = r_out_min;
  assign w_xfer    = in_valid && in_ready;
  // single comparator: second operand follows the phase
  assign w_b = r_state == CMP_MAX ? r_max : r_min;
  cmp4_onehot u_cmp (.i_a(r_smp), .i_b(w_b), .o_y(w_y));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_smp       <= '0;
      r_max       <= '0;
      r_min       <= '0;
      r_out_valid <= 1'b0;
      r_out_max   <= '0;
      r_out_min   <= '0;
`ifdef COMPARE_SCHED_INDEX_EN
      r_max_idx     <= '0;
      r_min_idx     <= '0;
      r_out_max_idx <= '0;
      r_out_min_idx <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_xfer) begin
          r_max   <= in_data;
          r_min   <= in_data;
          r_cnt   <= CNT_W'(1);
`ifdef COMPARE_SCHED_INDEX_EN
          r_max_idx <= '0;
          r_min_idx <= '0;
`endif
          r_state <= ACCEPT;
        end
        ACCEPT: if (w_xfer) begin
          r_smp   <= in_data;
          r_state <= CMP_MAX;
        end
        CMP_MAX: begin
          if (w_y == CMP_GT) begin
            r_max <= r_smp;
`ifdef COMPARE_SCHED_INDEX_EN
            r_max_idx <= r_cnt;
`endif
          end
          r_state <= CMP_MIN;
        end
        CMP_MIN: begin
          if (w_y == CMP_LT) begin
            r_min <= r_smp;
`ifdef COMPARE_SCHED_INDEX_EN
            r_min_idx <= r_cnt;
`endif
          end
          r_cnt   <= r_cnt + 1'b1;
          r_state <= r_cnt == LAST ? DONE : ACCEPT;
        end
        DONE: begin
          // result is published one cycle after entering DONE; ack only counts once visible
          if (r_out_valid && out_ack) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end else if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_max   <= r_max;
            r_out_min   <= r_min;
`ifdef COMPARE_SCHED_INDEX_EN
            r_out_max_idx <= r_max_idx;
            r_out_min_idx <= r_min_idx;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
